// File: rtl/cmd_comm_pkg.sv
// Shared types and constants for the command/response serial link.
package cmd_comm_pkg;

    localparam int CMD_BYTES  = 3;   // bytes per assembled command
    localparam int FRAME_BITS = 10;  // start + 8 data + stop

    // Command assembly: which byte of the 24-bit command is expected next
    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } asm_state_e;

    // Bit-level transmitter states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/cmd_resp_comm_uart_trcv.sv
// uart_trcv: 8N1 bit engines. RX oversamples a synchronized line with a
// midpoint-aligned baud counter; TX shifts one latched byte per request.
module uart_trcv
    import cmd_comm_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_valid_q, rx_ferr_q;

    // Two-flop synchronizer plus one delay flop for falling-edge detect; idle-high preset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Frame receiver: bit 0 is the start recheck at half a bit, 1..8 data, 9 stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_bit_q == 4'd0) begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q <= '0;
                    if (rx_s2_q) rx_busy_q <= 1'b0;  // glitch, not a start bit
                    else         rx_bit_q  <= 4'd1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            end else if (rx_cnt_q == BIT_END) begin
                rx_cnt_q <= '0;
                if (rx_bit_q == STOP_IDX) begin
                    rx_busy_q <= 1'b0;
                    if (rx_s2_q) rx_valid_q <= 1'b1;
                    else         rx_ferr_q  <= 1'b1;
                end else begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
        end
    end

    assign rx_byte_o  = rx_sh_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_ferr_o  = rx_ferr_q;

    // ---------------- transmitter ----------------
    tx_state_e     tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;

    // Transmitter state register; line idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q   <= TX_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Transmitter next state: each bit held BAUD_DIV cycles, done pulses after stop
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q + 1'b1;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
        case (tx_st_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (tx_start_i) begin
                    tx_st_d = TX_START;
                    tx_sh_d = tx_byte_i;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tx_st_d  = TX_DATA;
                    tx_bit_d = '0;
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d  = '0;
                    tx_st_d   = TX_IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                tx_st_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_busy_o = (tx_st_q != TX_IDLE);
    assign tx_done_o = tx_done_q;
    assign tx_o      = tx_q;

endmodule

// File: rtl/cmd_resp_comm.sv
// cmd_resp_comm: assembles three received bytes into a 24-bit command with a
// cmd_rdy/clr_cmd_rdy handshake, and transmits single response bytes.
// Optional CMD_ECHO_EN: echo each completed command's bytes on TX ahead of
// later responses (responses arriving meanwhile are held pending).
module cmd_resp_comm
    import cmd_comm_pkg::*;
#(
    parameter int          BAUD_DIV    = 868,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;
    logic [7:0] tx_byte;
    logic       tx_start, tx_busy, tx_done;

    uart_trcv #(.BAUD_DIV(BAUD_DIV)) u_trcv (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (RX),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .rx_ferr_o  (rx_ferr),
        .tx_byte_i  (tx_byte),
        .tx_start_i (tx_start),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done),
        .tx_o       (TX)
    );

    // ---------------- command assembly ----------------
    asm_state_e                asm_q, asm_d;
    logic [8*CMD_BYTES-1:8]    shadow_q, shadow_d;
    logic [23:0]               cmd_q, cmd_d;
    logic                      rdy_q, rdy_d;
    logic [19:0]               tmo_q, tmo_d;
    logic                      cmd_done;

    // Assembly state, shadow bytes, presented command and inter-byte timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q    <= WAIT_B0;
            shadow_q <= '0;
            cmd_q    <= '0;
            rdy_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            asm_q    <= asm_d;
            shadow_q <= shadow_d;
            cmd_q    <= cmd_d;
            rdy_q    <= rdy_d;
            tmo_q    <= tmo_d;
        end
    end

    // Assembly next state: framing error or timeout drops a partial command;
    // completion sets cmd_rdy and takes priority over the clear
    always_comb begin
        asm_d    = asm_q;
        shadow_d = shadow_q;
        cmd_d    = cmd_q;
        rdy_d    = clr_cmd_rdy ? 1'b0 : rdy_q;
        tmo_d    = (asm_q == WAIT_B0) ? 20'd0 : tmo_q + 20'd1;
        cmd_done = 1'b0;
        if (rx_ferr) begin
            asm_d = WAIT_B0;
            tmo_d = '0;
        end else if (rx_valid) begin
            tmo_d = '0;
            case (asm_q)
                WAIT_B0: begin
                    shadow_d[23:16] = rx_byte;
                    asm_d           = WAIT_B1;
                end
                WAIT_B1: begin
                    shadow_d[15:8] = rx_byte;
                    asm_d          = WAIT_B2;
                end
                WAIT_B2: begin
                    cmd_d    = {shadow_q, rx_byte};
                    rdy_d    = 1'b1;
                    asm_d    = WAIT_B0;
                    cmd_done = 1'b1;
                end
                default: asm_d = WAIT_B0;
            endcase
        end else if (asm_q != WAIT_B0 && tmo_q == TIMEOUT_CYC - 20'd1) begin
            asm_d = WAIT_B0;
            tmo_d = '0;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;

    // ---------------- transmit sequencing ----------------
`ifdef CMD_ECHO_EN
    logic [23:0] echo_buf_q, echo_buf_d;
    logic [1:0]  echo_cnt_q, echo_cnt_d;
    logic        cur_echo_q, cur_echo_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        echo_active;

    // Echo queue, pending response and whether the frame in flight is an echo
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_buf_q  <= '0;
            echo_cnt_q  <= '0;
            cur_echo_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
        end else begin
            echo_buf_q  <= echo_buf_d;
            echo_cnt_q  <= echo_cnt_d;
            cur_echo_q  <= cur_echo_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    // Echo bytes first (MSB first), then a held response, then a fresh request
    always_comb begin
        echo_buf_d  = echo_buf_q;
        echo_cnt_d  = echo_cnt_q;
        cur_echo_d  = cur_echo_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        tx_start    = 1'b0;
        tx_byte     = resp_data;
        echo_active = (echo_cnt_q != 2'd0) || (tx_busy && cur_echo_q);
        if (send_resp && echo_active && !pend_q) begin
            pend_d      = 1'b1;
            pend_byte_d = resp_data;
        end
        if (!tx_busy) begin
            if (echo_cnt_q != 2'd0) begin
                tx_start   = 1'b1;
                tx_byte    = echo_buf_q[23:16];
                echo_buf_d = {echo_buf_q[15:0], 8'h00};
                echo_cnt_d = echo_cnt_q - 2'd1;
                cur_echo_d = 1'b1;
            end else if (pend_q) begin
                tx_start   = 1'b1;
                tx_byte    = pend_byte_q;
                pend_d     = 1'b0;
                cur_echo_d = 1'b0;
            end else if (send_resp) begin
                tx_start   = 1'b1;
                cur_echo_d = 1'b0;
            end
        end
        if (cmd_done) begin
            echo_buf_d = cmd_d;
            echo_cnt_d = 2'(CMD_BYTES);
        end
    end

    assign resp_sent = tx_done && !cur_echo_q;
`else
    // Responses only: requests while busy are dropped by the idle qualifier
    assign tx_start  = send_resp && !tx_busy;
    assign tx_byte   = resp_data;
    assign resp_sent = tx_done;
`endif

endmodule

// File: tb/tb_cmd_resp_comm.sv
// Directed bench for cmd_resp_comm at BAUD_DIV=16, TIMEOUT_CYC=1000.
module tb_cmd_resp_comm;

    localparam int BD  = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rs_cnt   = 0;
    int rdy_rise = 0;
    logic rdy_prev = 1'b0;

    cmd_resp_comm #(.BAUD_DIV(BD), .TIMEOUT_CYC(20'(TMO))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_data   (resp_data),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (resp_sent) rs_cnt <= rs_cnt + 1;
        if (cmd_rdy && !rdy_prev) rdy_rise <= rdy_rise + 1;
        rdy_prev <= cmd_rdy;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_v;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_resp(input logic [7:0] d);
        resp_data = d;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
    endtask

    // Decode one TX frame: wait (bounded) for a low line, then sample bit centres
    task automatic get_frame(output logic [7:0] b, output logic stp, output int t0, output bit ok);
        ok = 1'b0; b = '0; stp = 1'b0; t0 = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (TX === 1'b0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            t0 = cyc;
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                b[i] = TX;
            end
            repeat (BD) @(negedge clk);
            stp = TX;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX); end
        checks++; if (cmd !== 24'h0) begin failures++; $display("FAIL reset_cmd got=%h exp=000000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", cmd_rdy); end
        checks++; if (resp_sent !== 1'b0) begin failures++; $display("FAIL reset_resp_sent got=%b exp=0", resp_sent); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Second request issued in the resp_sent cycle starts one cycle after the
    // 10-bit frame ends, so start-to-start spacing is 10*BD+1
    task automatic test_back_to_back();
        logic [7:0] b1, b2;
        logic s1, s2;
        int t1, t2, rs0;
        bit ok1, ok2, seen;
        rs0 = rs_cnt; seen = 1'b0;
        resp_data = 8'h55; send_resp = 1'b1;
        fork
            begin
                get_frame(b1, s1, t1, ok1);
                get_frame(b2, s2, t2, ok2);
            end
            begin
                @(negedge clk);
                send_resp = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (resp_sent) begin seen = 1'b1; break; end
                end
                if (seen) begin
                    resp_data = 8'h66; send_resp = 1'b1;
                    @(negedge clk);
                    send_resp = 1'b0;
                end
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (!(ok1 && ok2 && seen)) begin failures++; $display("FAIL b2b_timeout got=%b%b%b exp=111", ok1, ok2, seen); end
        checks++; if (b1 !== 8'h55 || s1 !== 1'b1) begin failures++; $display("FAIL b2b_byte1 got=%h/%b exp=55/1", b1, s1); end
        checks++; if (b2 !== 8'h66 || s2 !== 1'b1) begin failures++; $display("FAIL b2b_byte2 got=%h/%b exp=66/1", b2, s2); end
        checks++; if (t2 - t1 !== 10 * BD + 1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, 10 * BD + 1); end
        checks++; if (rs_cnt - rs0 !== 2) begin failures++; $display("FAIL b2b_resp_sent got=%0d exp=2", rs_cnt - rs0); end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] b;
        logic s;
        int t, rs0;
        bit ok, extra;
        rs0 = rs_cnt; extra = 1'b0;
        resp_data = 8'hAA; send_resp = 1'b1;
        fork
            get_frame(b, s, t, ok);
            begin
                @(negedge clk);
                send_resp = 1'b0;
                repeat (4) @(negedge clk);
                pulse_resp(8'hBB);
            end
        join
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (TX === 1'b0) extra = 1'b1;
        end
        checks++; if (!ok || b !== 8'hAA) begin failures++; $display("FAIL busy_byte got=%h exp=aa", b); end
        checks++; if (extra !== 1'b0) begin failures++; $display("FAIL busy_extra_frame got=%b exp=0", extra); end
        checks++; if (rs_cnt - rs0 !== 1) begin failures++; $display("FAIL busy_resp_sent got=%0d exp=1", rs_cnt - rs0); end
    endtask

    task automatic test_cmd();
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'hA5, 1'b1);
        checks++; if (cmd !== 24'h0213A5) begin failures++; $display("FAIL cmd_value got=%h exp=0213a5", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL cmd_rdy_set got=%b exp=1", cmd_rdy); end
        clear_rdy();
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL cmd_rdy_clr got=%b exp=0", cmd_rdy); end
    endtask

    task automatic test_timeout();
        int r0;
        r0 = rdy_rise;
        send_byte(8'h05, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (TMO + 10) @(negedge clk);
        checks++; if (rdy_rise - r0 !== 0 || cmd !== 24'h0213A5) begin failures++; $display("FAIL tmo_partial got=%0d/%h exp=0/0213a5", rdy_rise - r0, cmd); end
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++; if (cmd !== 24'h080000) begin failures++; $display("FAIL tmo_cmd got=%h exp=080000", cmd); end
        checks++; if (rdy_rise - r0 !== 1) begin failures++; $display("FAIL tmo_rdy_rises got=%0d exp=1", rdy_rise - r0); end
        clear_rdy();
    endtask

    task automatic test_gap_within_timeout();
        send_byte(8'h0A, 1'b1);
        repeat (TMO / 2) @(negedge clk);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        checks++; if (cmd !== 24'h0A0B0C || cmd_rdy !== 1'b1) begin failures++; $display("FAIL gap_cmd got=%h/%b exp=0a0b0c/1", cmd, cmd_rdy); end
        clear_rdy();
    endtask

    task automatic test_framing_error();
        int r0;
        r0 = rdy_rise;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        checks++; if (cmd !== 24'h223344) begin failures++; $display("FAIL ferr_cmd got=%h exp=223344", cmd); end
        checks++; if (rdy_rise - r0 !== 1) begin failures++; $display("FAIL ferr_rdy_rises got=%0d exp=1", rdy_rise - r0); end
        clear_rdy();
    endtask

    // clr_cmd_rdy held high across the completion: cmd_rdy can only read 1 if set wins
    task automatic test_set_wins();
        bit seen;
        int rs0;
`ifdef CMD_ECHO_EN
        logic [7:0] eb [3];
        logic es;
        int et;
        bit eok [3];
        repeat (600) @(negedge clk);
`endif
        seen = 1'b0;
        rs0 = rs_cnt;
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1);
        clr_cmd_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL sw_precleared got=%b exp=0", cmd_rdy); end
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (cmd_rdy === 1'b1) begin seen = 1'b1; break; end
                end
                clr_cmd_rdy = 1'b0;
                checks++; if (seen !== 1'b1) begin failures++; $display("FAIL sw_set_wins got=%b exp=1", seen); end
                checks++; if (cmd !== 24'h0213A5) begin failures++; $display("FAIL sw_cmd got=%h exp=0213a5", cmd); end
                @(negedge clk);
                checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL sw_rdy_hold got=%b exp=1", cmd_rdy); end
`ifdef CMD_ECHO_EN
                for (int k = 0; k < 3; k++) get_frame(eb[k], es, et, eok[k]);
                checks++; if (eb[0] !== 8'h02 || eb[1] !== 8'h13 || eb[2] !== 8'hA5)
                    begin failures++; $display("FAIL echo_bytes got=%h %h %h exp=02 13 a5", eb[0], eb[1], eb[2]); end
                repeat (20) @(negedge clk);
                checks++; if (rs_cnt - rs0 !== 0) begin failures++; $display("FAIL echo_resp_sent got=%0d exp=0", rs_cnt - rs0); end
`endif
            end
        join
        checks++; if (rs_cnt - rs0 !== 0) begin failures++; $display("FAIL sw_no_resp_sent got=%0d exp=0", rs_cnt - rs0); end
    endtask

    task automatic test_reset_midframe();
        int rs0;
        bit low_seen;
        rs0 = rs_cnt; low_seen = 1'b0;
        pulse_resp(8'h3C);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (TX !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b exp=1", TX); end
        checks++; if (cmd !== 24'h0 || cmd_rdy !== 1'b0) begin failures++; $display("FAIL rstmid_cmd got=%h/%b exp=000000/0", cmd, cmd_rdy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (TX === 1'b0) low_seen = 1'b1;
        end
        checks++; if (low_seen !== 1'b0) begin failures++; $display("FAIL rstmid_tx_idle got=%b exp=0", low_seen); end
        checks++; if (rs_cnt - rs0 !== 0) begin failures++; $display("FAIL rstmid_resp_sent got=%0d exp=0", rs_cnt - rs0); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_busy_ignore();
        test_cmd();
        test_timeout();
        test_framing_error();
        test_gap_within_timeout();
        test_set_wins();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_resp_comm.md
Name: cmd_resp_comm

Overview:
Host-side end of the command/response interface used by the oscilloscope digital core. It receives 8N1 serial bytes on RX and assembles three bytes into a 24-bit command, presented with a cmd_rdy/clr_cmd_rdy handshake. It serializes single response bytes requested by send_resp onto TX and acknowledges each with resp_sent. It sits between the board UART pins and the core's cmd/cmd_rdy/clr_cmd_rdy/resp_data/send_resp/resp_sent ports.

Parameters:
BAUD_DIV, 868, clk cycles per serial bit (115200 baud at 100 MHz); must be >= 16.
TIMEOUT_CYC, 20'd1000000, maximum idle clk cycles allowed between bytes of one command.

Ports:
clk  input  1  system clock; the block's only clock.
rst_n  input  1  asynchronous active-low reset.
RX  input  1  serial data from host, asynchronous to clk.
TX  output  1  serial data to host.
cmd  output  24  assembled command.
cmd_rdy  output  1  cmd is valid.
clr_cmd_rdy  input  1  core has consumed cmd.
resp_data  input  8  response byte.
send_resp  input  1  one-cycle request to transmit resp_data.
resp_sent  output  1  one-cycle pulse when the response byte has finished.

Behaviour:
- Reset (asynchronous, active-low): TX=1, cmd=0, cmd_rdy=0, resp_sent=0, assembly FSM in WAIT_B0, transmitter idle.
- RX is passed through a two-flop synchronizer, and the synchronizer is preset to 1.
- Start is detected on a falling edge of synchronized RX. The start bit is rechecked at BAUD_DIV/2; if it reads high, the event is treated as a glitch and the receiver returns to idle.
- Each data bit is sampled once per BAUD_DIV cycles after that midpoint, LSB first. The stop bit is sampled at its midpoint.
- If the stop bit reads 0, it is a framing error: the byte is discarded and the assembly FSM returns to WAIT_B0.
- Assembly FSM, MSB byte first:
  - WAIT_B0 -> WAIT_B1 on a good byte, stored in cmd_shadow[23:16].
  - WAIT_B1 -> WAIT_B2 on a good byte, stored in [15:8].
  - WAIT_B2 -> WAIT_B0 on a good byte, stored in [7:0].
  - On the WAIT_B2 completion, cmd <= {shadow[23:8], byte} and cmd_rdy=1 on the next clk edge.
- cmd changes only when a new command completes. A command completing while cmd_rdy=1 overwrites cmd, and cmd_rdy stays 1. No queue.
- clr_cmd_rdy clears cmd_rdy on the next edge. If clr_cmd_rdy coincides with a completion, set wins.
- Inter-byte timeout: a counter runs in WAIT_B1/WAIT_B2 and resets on each good byte. When it reaches TIMEOUT_CYC-1, the partial command is dropped and the FSM goes to WAIT_B0. cmd and cmd_rdy are unaffected.
- Transmit:
  - When idle, send_resp latches resp_data and TX drives the start bit on the next edge.
  - Frame is start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles (10*BAUD_DIV total).
  - resp_sent pulses for 1 cycle on the cycle after the stop bit completes, and the transmitter returns to idle in that same cycle.
  - send_resp while busy is ignored; the latched byte is not altered.
  - send_resp in the same cycle as resp_sent is accepted (back-to-back frames).
- RX and TX paths are fully independent (full duplex).
- Reset mid-frame aborts both paths immediately. TX returns high, and no resp_sent is issued for the aborted byte.

Optional Feature:
Macro CMD_ECHO_EN.
- Defined: each completed command's three bytes are echoed on TX before any later send_resp is accepted.
  - The transmitter runs an ECHO sequence, MSB byte first.
  - resp_sent does not pulse for echo bytes.
  - send_resp arriving during the echo is held pending and sent afterwards with its normal resp_sent.
- Undefined: no echo logic; TX carries only responses.

Decomposition:
- Shared package cmd_comm_pkg holds:
  - assembly state enum (WAIT_B0/WAIT_B1/WAIT_B2);
  - tx state enum (TX_IDLE/TX_START/TX_DATA/TX_STOP[/TX_ECHO]);
  - constants CMD_BYTES=3 and FRAME_BITS=10.
- One sub-module, uart_trcv, contains the bit-level RX and TX engines with their baud counters. It exposes rx_byte/rx_valid/rx_ferr and tx_byte/tx_start/tx_busy/tx_done.
- The top level holds the assembly FSM, timeout counter, handshake and echo sequencing.

Test Plan:
- Bytes 0x02, 0x13, 0xA5 with BAUD_DIV=16 -> cmd=24'h0213A5, cmd_rdy=1 for one edge after the third stop-bit sample. clr_cmd_rdy -> cmd_rdy=0 on the next cycle.
- Bytes 0x05, 0x01, idle TIMEOUT_CYC+10 cycles, then 0x08, 0x00, 0x00 -> cmd=24'h080000. The partial 0x0501 is never presented.
- 0x11 sent with stop bit=0, then 0x22, 0x33, 0x44 -> cmd=24'h223344.
- 0x55 and 0x66 sent as back-to-back send_resp (second issued on the resp_sent cycle) -> TX shows two contiguous frames of 10*16 cycles each, with two resp_sent pulses.
- send_resp(0xAA) then send_resp(0xBB) 5 cycles later -> only 0xAA is transmitted, with one resp_sent.
- Third byte's completion coincident with clr_cmd_rdy -> cmd_rdy stays 1. With CMD_ECHO_EN, TX echoes 0x02 0x13 0xA5 with no resp_sent.
